// File: rtl/ysyx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx_pkg : shared fetch-path defaults and the {pc, inst} buffer entry.      |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
package ysyx_pkg;

  localparam int          c_xlen     = 32;
  localparam int          c_ilen     = 32;
  localparam logic [31:0] c_reset_pc = 32'h8000_0000;

  typedef struct packed {
    logic [c_xlen-1:0] pc;
    logic [c_ilen-1:0] inst;
  } fetch_entry_t;

endpackage
`default_nettype wire

// File: rtl/ysyx_ifu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx_ifu_if : instruction-memory request/response and IDU delivery ports.   |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
interface ysyx_ifu_if
  import ysyx_pkg::*;
#(
  parameter int XLEN = c_xlen,
  parameter int ILEN = c_ilen
);

  logic            imem_req_valid;
  logic            imem_req_ready;
  logic [XLEN-1:0] imem_req_addr;
  logic            imem_rsp_valid;
  logic [ILEN-1:0] imem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [ILEN-1:0] inst;
  logic [XLEN-1:0] inst_pc;

  // master is the fetch unit; slave is the memory + decode side
  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
    output inst_valid, inst, inst_pc,
    input  inst_ready
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data,
    input  inst_valid, inst, inst_pc,
    output inst_ready
  );

endinterface
`default_nettype wire

// File: rtl/ysyx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx_fifo : power-of-two synchronous FIFO with flush; head reads 0 empty.   |
// | Revision  : 1.0                                                             |
// +----------------------------------------------------------------------------+
module ysyx_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic [WIDTH-1:0]             head
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH+1);

  logic [WIDTH-1:0]   mem_q [DEPTH];
  logic [WIDTH-1:0]   mem_d [DEPTH];
  logic [c_ptr_w-1:0] wr_ptr_q, wr_ptr_d;
  logic [c_ptr_w-1:0] rd_ptr_q, rd_ptr_d;
  logic [c_cnt_w-1:0] count_q, count_d;
  logic               w_push;
  logic               w_pop;

  always_comb begin
    w_pop    = pop && (count_q != '0) && !flush;
    // a push at full is only legal when the head leaves in the same cycle
    w_push   = push && !flush && ((count_q != c_cnt_w'(DEPTH)) || w_pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + c_ptr_w'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
      end
      count_d = count_q + c_cnt_w'(w_push) - c_cnt_w'(w_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign count = count_q;
  assign head  = (count_q != '0) ? mem_q[rd_ptr_q] : '0;

endmodule
`default_nettype wire

// File: rtl/ysyx_ifu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx_ifu : credit-limited instruction fetch with response drop on redirect. |
// | Revision : 1.0                                                              |
// +----------------------------------------------------------------------------+
module ysyx_ifu
  import ysyx_pkg::*;
#(
  parameter int              XLEN     = c_xlen,
  parameter int              ILEN     = c_ilen,
  parameter int              DEPTH    = 2,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(c_reset_pc)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  ysyx_ifu_if.master      bus
);

  localparam int c_cnt_w = $clog2(DEPTH+1);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [ILEN-1:0] inst;
  } entry_t;

  logic [XLEN-1:0]    fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0]    rsp_pc_q,   rsp_pc_d;
  logic [c_cnt_w-1:0] inflight_q, inflight_d;
  logic [c_cnt_w-1:0] drop_q,     drop_d;

  logic [c_cnt_w-1:0]      w_fifo_count;
  logic [XLEN+ILEN-1:0]    w_head_bits;
  entry_t                  w_head;
  entry_t                  w_push_entry;
  logic [c_cnt_w:0]        w_occupancy;
  logic                    w_req_valid;
  logic                    w_req_fire;
  logic                    w_rsp;
  logic                    w_drop;
  logic                    w_push;
  logic                    w_inst_valid;
  logic                    w_pop;

  always_comb begin
    w_occupancy  = {1'b0, w_fifo_count} + {1'b0, inflight_q};
    w_req_valid  = !redirect && (w_occupancy < (c_cnt_w+1)'(DEPTH));
    w_req_fire   = w_req_valid && bus.imem_req_ready;
    // a response with nothing outstanding is a protocol error and is ignored
    w_rsp        = bus.imem_rsp_valid && (inflight_q != '0);
    w_drop       = w_rsp && (drop_q != '0);
    w_push       = w_rsp && !w_drop && !redirect;
    w_inst_valid = (w_fifo_count != '0);
    w_pop        = w_inst_valid && bus.inst_ready && !redirect;
    w_push_entry = '{pc: rsp_pc_q, inst: bus.imem_rsp_data};
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + c_cnt_w'(w_req_fire) - c_cnt_w'(w_rsp);
    drop_d     = drop_q - c_cnt_w'(w_drop);
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
      // drops already pending are a subset of inflight, so after a redirect
      // every response still outstanding is stale -- that keeps the count exact
      // across back-to-back redirects
      drop_d     = inflight_q - c_cnt_w'(w_rsp);
    end else begin
      if (w_req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (w_push)     rsp_pc_d   = rsp_pc_q + XLEN'(4);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  ysyx_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (redirect),
    .push      (w_push),
    .push_data (w_push_entry),
    .pop       (w_pop),
    .count     (w_fifo_count),
    .head      (w_head_bits)
  );

  assign w_head             = entry_t'(w_head_bits);
  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_req_addr  = fetch_pc_q;
  assign bus.inst_valid     = w_inst_valid;
  assign bus.inst           = w_head.inst;
  assign bus.inst_pc        = w_head.pc;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_ifu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_ysyx_ifu : randomized bench for ysyx_ifu against a queue-based model.    |
// | Revision    : 1.0                                                           |
// +----------------------------------------------------------------------------+
module tb_ysyx_ifu;
  import ysyx_pkg::*;

  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;

  ysyx_ifu_if #(.XLEN(32), .ILEN(32)) bus_if ();

  ysyx_ifu #(
    .XLEN(32), .ILEN(32), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .bus         (bus_if)
  );

  always #5 clk = ~clk;

  // outstanding request: address, cycle the memory answers, and whether a
  // redirect has since made it stale
  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
  } ost_t;

  ost_t         ost_q[$];
  fetch_entry_t fifo_m[$];
  logic [31:0]  m_fetch_pc, m_rsp_pc;
  int           cyc, last_due;
  int           checks = 0, failures = 0;
  logic         obs_req_valid, obs_inst_valid;
  logic [31:0]  obs_req_addr, obs_inst, obs_inst_pc;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h0000_0013;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ost_q.delete();
    fifo_m.delete();
    m_fetch_pc = RESET_PC;
    m_rsp_pc   = RESET_PC;
    cyc        = 0;
    last_due   = -1;
  endtask

  // one clock cycle: drive at the falling edge, compare, advance the model
  task automatic step(input bit req_rdy, input bit i_rdy, input bit redir,
                      input logic [31:0] rpc, input int lat);
    ost_t         o;
    bit           rsp_v;
    logic [31:0]  rsp_d;
    bit           exp_rv, exp_iv, fire;
    logic [31:0]  exp_inst, exp_pc;
    fetch_entry_t e;
    int           d;
    @(negedge clk);
    rsp_v = 1'b0;
    rsp_d = '0;
    if (ost_q.size() > 0 && ost_q[0].due <= cyc) begin
      o     = ost_q.pop_front();
      rsp_v = 1'b1;
      rsp_d = mem_data(o.addr);
    end
    redirect              = redir;
    redirect_pc           = rpc;
    bus_if.imem_req_ready = req_rdy;
    bus_if.imem_rsp_valid = rsp_v;
    bus_if.imem_rsp_data  = rsp_d;
    bus_if.inst_ready     = i_rdy;
    #1;
    exp_rv   = !redir && ((fifo_m.size() + ost_q.size() + (rsp_v ? 1 : 0)) < DEPTH);
    exp_iv   = (fifo_m.size() != 0);
    exp_inst = exp_iv ? fifo_m[0].inst : 32'h0;
    exp_pc   = exp_iv ? fifo_m[0].pc   : 32'h0;
    obs_req_valid  = bus_if.imem_req_valid;
    obs_req_addr   = bus_if.imem_req_addr;
    obs_inst_valid = bus_if.inst_valid;
    obs_inst       = bus_if.inst;
    obs_inst_pc    = bus_if.inst_pc;
    chk("req_valid",  {31'b0, obs_req_valid},  {31'b0, exp_rv});
    chk("req_addr",   obs_req_addr,            m_fetch_pc);
    chk("inst_valid", {31'b0, obs_inst_valid}, {31'b0, exp_iv});
    chk("inst",       obs_inst,                exp_inst);
    chk("inst_pc",    obs_inst_pc,             exp_pc);
    fire = exp_rv && req_rdy;
    if (!redir && exp_iv && i_rdy) void'(fifo_m.pop_front());
    if (rsp_v && !o.stale && !redir) begin
      e.pc   = m_rsp_pc;
      e.inst = rsp_d;
      fifo_m.push_back(e);
      m_rsp_pc = m_rsp_pc + 32'd4;
    end
    if (fire) begin
      d = cyc + lat;
      if (d <= last_due) d = last_due + 1;
      last_due = d;
      ost_q.push_back('{addr: m_fetch_pc, due: d, stale: 1'b0});
      m_fetch_pc = m_fetch_pc + 32'd4;
    end
    if (redir) begin
      fifo_m.delete();
      foreach (ost_q[i]) ost_q[i].stale = 1'b1;
      m_fetch_pc = rpc;
      m_rsp_pc   = rpc;
    end
    cyc++;
  endtask

  task automatic do_reset();
    rst                   = 1'b0;
    redirect              = 1'b0;
    redirect_pc           = '0;
    bus_if.imem_req_ready = 1'b0;
    bus_if.imem_rsp_valid = 1'b0;
    bus_if.imem_rsp_data  = '0;
    bus_if.inst_ready     = 1'b0;
    #1;
    chk("rst_inst_valid", {31'b0, bus_if.inst_valid}, 32'h0);
    chk("rst_inst",       bus_if.inst,                32'h0);
    chk("rst_inst_pc",    bus_if.inst_pc,             32'h0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_req_valid", {31'b0, bus_if.imem_req_valid}, 32'h1);
    chk("rst_req_addr",  bus_if.imem_req_addr,           32'h8000_0000);
  endtask

  initial begin
    logic [31:0] pcs[$];
    logic [31:0] r;
    bit          found;

    // reset and streaming with a 1-cycle memory
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 1);
      if (i < 2)  chk("stream_early_invalid", {31'b0, obs_inst_valid}, 32'h0);
      if (i == 2) chk("stream_first_valid",   {31'b0, obs_inst_valid}, 32'h1);
      if (obs_inst_valid) begin
        pcs.push_back(obs_inst_pc);
        if (obs_inst !== 32'h0) chk("stream_inst", obs_inst, mem_data(obs_inst_pc));
      end
    end
    chk("stream_count_ge4", {31'b0, pcs.size() >= 4}, 32'h1);
    if (pcs.size() >= 4) begin
      chk("stream_pc0", pcs[0], 32'h8000_0000);
      chk("stream_pc1", pcs[1], 32'h8000_0004);
      chk("stream_pc2", pcs[2], 32'h8000_0008);
      chk("stream_pc3", pcs[3], 32'h8000_000C);
    end

    // backpressure: credits run out after DEPTH requests
    do_reset();
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b0, 1'b0, 32'h0, 1);
      if (i < 2)  chk("bp_req_open",   {31'b0, obs_req_valid}, 32'h1);
      if (i >= 2) chk("bp_req_closed", {31'b0, obs_req_valid}, 32'h0);
    end
    step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    chk("bp_head0", obs_inst_pc, 32'h8000_0000);
    step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    chk("bp_head1", obs_inst_pc, 32'h8000_0004);

    // redirect with two requests in flight on a 3-cycle memory
    do_reset();
    step(1'b1, 1'b1, 1'b0, 32'h0, 3);
    step(1'b1, 1'b1, 1'b0, 32'h0, 3);
    step(1'b1, 1'b1, 1'b1, 32'h8000_0100, 3);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 3);
      if (obs_inst_valid) begin
        found = 1'b1;
        chk("redir_first_pc", obs_inst_pc, 32'h8000_0100);
      end
    end
    chk("redir_seen", {31'b0, found}, 32'h1);

    // redirect coinciding with a response and a pop
    do_reset();
    step(1'b1, 1'b0, 1'b0, 32'h0, 2);
    step(1'b1, 1'b0, 1'b0, 32'h0, 2);
    step(1'b1, 1'b0, 1'b0, 32'h0, 2);
    step(1'b1, 1'b1, 1'b1, 32'h8000_0200, 2);
    chk("coinc_valid_before", {31'b0, obs_inst_valid}, 32'h1);
    step(1'b1, 1'b1, 1'b0, 32'h0, 2);
    chk("coinc_empty_after", {31'b0, obs_inst_valid}, 32'h0);
    chk("coinc_new_addr",    obs_req_addr,            32'h8000_0200);
    found = 1'b0;
    for (int i = 0; i < 30 && !found; i++) begin
      step(1'b1, 1'b1, 1'b0, 32'h0, 2);
      if (obs_inst_valid) begin
        found = 1'b1;
        chk("coinc_first_pc", obs_inst_pc, 32'h8000_0200);
      end
    end
    chk("coinc_seen", {31'b0, found}, 32'h1);

    // asynchronous reset between edges while the buffer holds data
    do_reset();
    for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 32'h0, 1);
    @(posedge clk);
    #2;
    chk("async_pre_valid", {31'b0, bus_if.inst_valid}, 32'h1);
    rst = 1'b0;
    #1;
    chk("async_inst_valid", {31'b0, bus_if.inst_valid},     32'h0);
    chk("async_inst_pc",    bus_if.inst_pc,                 32'h0);
    chk("async_req_addr",   bus_if.imem_req_addr,           32'h8000_0000);
    chk("async_req_valid",  {31'b0, bus_if.imem_req_valid}, 32'h1);
    do_reset();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      r = $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0, {r[31:2], 2'b00}, $urandom_range(1, 4));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
`default_nettype wire
